// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational 32-bit ALU between two requesters.
// Round-robin grant, registered ALU operands, one-cycle EXEC capture and a
// per-requester response handshake. Illegal opcodes never reach the ALU.
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_aluc,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_aluc,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_r,
    output logic              rsp_zero,
    output logic              rsp_carry,
    output logic              rsp_negative,
    output logic              rsp_overflow,
    output logic              rsp_flag,
    output logic              rsp_err,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_aluc,
    input  logic [DATA_W-1:0] alu_r,
    input  logic              alu_zero,
    input  logic              alu_carry,
    input  logic              alu_negative,
    input  logic              alu_overflow,
    input  logic              alu_flag
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_q;
    logic              ptr_q;
    logic              owner_q;
    logic              err_q;
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic [OP_W-1:0]   alu_aluc_q;
    logic              rsp0_valid_q;
    logic              rsp1_valid_q;
    logic [DATA_W-1:0] rsp_r_q;
    logic              rsp_zero_q;
    logic              rsp_carry_q;
    logic              rsp_negative_q;
    logic              rsp_overflow_q;
    logic              rsp_flag_q;
    logic              rsp_err_q;

    logic              grant_valid_s;
    logic              grant_port_s;
    logic              accept_s;
    logic              rsp_take_s;
    logic              sel_legal_s;
    logic [DATA_W-1:0] sel_a_s;
    logic [DATA_W-1:0] sel_b_s;
    logic [OP_W-1:0]   sel_aluc_s;

    // Opcodes the ALU implements; everything else is answered with rsp_err.
    function automatic logic aluc_legal(input logic [OP_W-1:0] op);
        logic ok;
        case (op)
            6'b100000, 6'b100001, 6'b100010, 6'b100011,
            6'b100100, 6'b100101, 6'b100110, 6'b100111,
            6'b101010, 6'b101011,
            6'b000000, 6'b000010, 6'b000011, 6'b000100,
            6'b000110, 6'b000111, 6'b001111: ok = 1'b1;
            default:                          ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Only the set-less-than opcodes produce a meaningful ALU flag.
    function automatic logic aluc_sets_flag(input logic [OP_W-1:0] op);
        logic f;
        case (op)
            6'b101010, 6'b101011: f = 1'b1;
            default:              f = 1'b0;
        endcase
        return f;
    endfunction

    // Maps anything other than a clean 1 (0, X, Z) to 0 so status never goes unknown.
    function automatic logic clean_bit(input logic b);
        logic o;
        if (b == 1'b1) begin
            o = 1'b1;
        end else begin
            o = 1'b0;
        end
        return o;
    endfunction

    // Round-robin grant and operand selection for the granted requester.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_port_s  = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_valid_s = 1'b1;
            grant_port_s  = ptr_q;
        end else if (req0_valid) begin
            grant_valid_s = 1'b1;
            grant_port_s  = 1'b0;
        end else if (req1_valid) begin
            grant_valid_s = 1'b1;
            grant_port_s  = 1'b1;
        end else begin
            grant_valid_s = 1'b0;
            grant_port_s  = 1'b0;
        end
        if (grant_port_s) begin
            sel_a_s    = req1_a;
            sel_b_s    = req1_b;
            sel_aluc_s = req1_aluc;
        end else begin
            sel_a_s    = req0_a;
            sel_b_s    = req0_b;
            sel_aluc_s = req0_aluc;
        end
        sel_legal_s = aluc_legal(sel_aluc_s);
        accept_s    = rst_n && (state_q == ST_IDLE) && grant_valid_s;
        rsp_take_s  = owner_q ? rsp1_ready : rsp0_ready;
    end

    assign req0_ready   = accept_s && !grant_port_s;
    assign req1_ready   = accept_s && grant_port_s;
    assign rsp0_valid   = rsp0_valid_q;
    assign rsp1_valid   = rsp1_valid_q;
    assign rsp_r        = rsp_r_q;
    assign rsp_zero     = rsp_zero_q;
    assign rsp_carry    = rsp_carry_q;
    assign rsp_negative = rsp_negative_q;
    assign rsp_overflow = rsp_overflow_q;
    assign rsp_flag     = rsp_flag_q;
    assign rsp_err      = rsp_err_q;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_aluc     = alu_aluc_q;

    // Control FSM: accept in IDLE, drive the ALU for one EXEC cycle, hold the response in RESP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            ptr_q          <= 1'b0;
            owner_q        <= 1'b0;
            err_q          <= 1'b0;
            alu_a_q        <= {DATA_W{1'b0}};
            alu_b_q        <= {DATA_W{1'b0}};
            alu_aluc_q     <= {OP_W{1'b0}};
            rsp0_valid_q   <= 1'b0;
            rsp1_valid_q   <= 1'b0;
            rsp_r_q        <= {DATA_W{1'b0}};
            rsp_zero_q     <= 1'b0;
            rsp_carry_q    <= 1'b0;
            rsp_negative_q <= 1'b0;
            rsp_overflow_q <= 1'b0;
            rsp_flag_q     <= 1'b0;
            rsp_err_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        owner_q <= grant_port_s;
                        err_q   <= !sel_legal_s;
                        // An illegal opcode leaves the ALU inputs parked at zero.
                        if (sel_legal_s) begin
                            alu_a_q    <= sel_a_s;
                            alu_b_q    <= sel_b_s;
                            alu_aluc_q <= sel_aluc_s;
                        end else begin
                            alu_a_q    <= {DATA_W{1'b0}};
                            alu_b_q    <= {DATA_W{1'b0}};
                            alu_aluc_q <= {OP_W{1'b0}};
                        end
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (err_q) begin
                        rsp_r_q        <= {DATA_W{1'b0}};
                        rsp_zero_q     <= 1'b0;
                        rsp_carry_q    <= 1'b0;
                        rsp_negative_q <= 1'b0;
                        rsp_overflow_q <= 1'b0;
                        rsp_flag_q     <= 1'b0;
                        rsp_err_q      <= 1'b1;
                    end else begin
                        rsp_r_q        <= alu_r;
                        rsp_zero_q     <= clean_bit(alu_zero);
                        rsp_carry_q    <= clean_bit(alu_carry);
                        rsp_negative_q <= clean_bit(alu_negative);
                        rsp_overflow_q <= clean_bit(alu_overflow);
                        rsp_flag_q     <= aluc_sets_flag(alu_aluc_q) ? clean_bit(alu_flag) : 1'b0;
                        rsp_err_q      <= 1'b0;
                    end
                    alu_a_q      <= {DATA_W{1'b0}};
                    alu_b_q      <= {DATA_W{1'b0}};
                    alu_aluc_q   <= {OP_W{1'b0}};
                    rsp0_valid_q <= !owner_q;
                    rsp1_valid_q <= owner_q;
                    state_q      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_take_s) begin
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        ptr_q        <= !owner_q;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: randomized and directed stimulus against a transaction-level
// reference model, with a per-cycle compare process and literal spot checks.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = 32'd0, req0_b = 32'd0, req1_a = 32'd0, req1_b = 32'd0;
    logic [5:0]  req0_aluc = 6'd0, req1_aluc = 6'd0;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [31:0] rsp_r;
    logic        rsp_zero, rsp_carry, rsp_negative, rsp_overflow, rsp_flag, rsp_err;
    logic [31:0] alu_a, alu_b, alu_r;
    logic [5:0]  alu_aluc;
    logic        alu_zero, alu_carry, alu_negative, alu_overflow, alu_flag;

    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.DATA_W(32), .OP_W(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_aluc(req0_aluc),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_aluc(req1_aluc),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_r(rsp_r), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_negative(rsp_negative),
        .rsp_overflow(rsp_overflow), .rsp_flag(rsp_flag), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc), .alu_r(alu_r),
        .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_negative(alu_negative),
        .alu_overflow(alu_overflow), .alu_flag(alu_flag)
    );

    localparam logic [5:0] LEGAL_OPS [17] = '{
        6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
        6'b100110, 6'b100111, 6'b101010, 6'b101011, 6'b000000, 6'b000010,
        6'b000011, 6'b000100, 6'b000110, 6'b000111, 6'b001111};

    typedef struct packed {
        logic [31:0] r;
        logic z; logic c; logic n; logic v; logic f;
    } alu_res_t;

    typedef struct packed {
        logic [31:0] r;
        logic z; logic c; logic n; logic v; logic f; logic e;
    } rsp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  op;
    } op_t;

    function automatic logic is_legal(input logic [5:0] op);
        for (int i = 0; i < 17; i++) begin
            if (LEGAL_OPS[i] == op) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Reference ALU; drives the raw flag high for non-compare ops so gating is observable.
    function automatic alu_res_t alu_eval(input logic [31:0] a, input logic [31:0] b, input logic [5:0] op);
        alu_res_t o;
        logic [32:0] w;
        o = '0;
        w = {1'b0, a} + {1'b0, b};
        case (op)
            6'b100000, 6'b100001: begin
                o.r = w[31:0]; o.c = w[32];
                o.v = (a[31] == b[31]) && (o.r[31] != a[31]);
            end
            6'b100010, 6'b100011: begin
                o.r = a - b; o.c = (a < b);
                o.v = (a[31] != b[31]) && (o.r[31] != a[31]);
            end
            6'b100100: o.r = a & b;
            6'b100101: o.r = a | b;
            6'b100110: o.r = a ^ b;
            6'b100111: o.r = ~(a | b);
            6'b101010: o.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'b101011: o.r = (a < b) ? 32'd1 : 32'd0;
            6'b000000, 6'b000100: o.r = b << a[4:0];
            6'b000010, 6'b000110: o.r = b >> a[4:0];
            6'b000011, 6'b000111: o.r = 32'($signed(b) >>> a[4:0]);
            6'b001111: o.r = {b[15:0], 16'h0000};
            default: o.r = 32'hDEAD_BEEF;
        endcase
        o.z = (o.r == 32'd0);
        o.n = o.r[31];
        o.f = (op == 6'b101010 || op == 6'b101011) ? o.r[0] : 1'b1;
        return o;
    endfunction

    function automatic rsp_t expect_rsp(input logic [31:0] a, input logic [31:0] b, input logic [5:0] op);
        rsp_t e;
        alu_res_t x;
        e = '0;
        x = alu_eval(a, b, op);
        if (!is_legal(op)) begin
            e.e = 1'b1;
        end else begin
            e.r = x.r; e.z = x.z; e.c = x.c; e.n = x.n; e.v = x.v;
            e.f = (op == 6'b101010 || op == 6'b101011) ? x.f : 1'b0;
        end
        return e;
    endfunction

    function automatic logic pick_port(input logic v0, input logic v1, input logic p);
        if (v0 && v1) return p;
        return v1;
    endfunction

    // ALU behaviour seen by the DUT.
    alu_res_t alu_o;
    always_comb begin
        alu_o = alu_eval(alu_a, alu_b, alu_aluc);
    end
    assign alu_r = alu_o.r;
    assign alu_zero = alu_o.z;
    assign alu_carry = alu_o.c;
    assign alu_negative = alu_o.n;
    assign alu_overflow = alu_o.v;
    assign alu_flag = alu_o.f;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: 0 = waiting for work, 1 = ALU busy, 2 = answer pending.
    int          m_phase = 0;
    logic        m_ptr = 1'b0, m_owner = 1'b0;
    logic [31:0] m_a = 32'd0, m_b = 32'd0;
    logic [5:0]  m_op = 6'd0;
    rsp_t        m_rsp = '0;
    int          order_q[$];

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_ptr   <= 1'b0;
            m_rsp   <= '0;
        end else if (m_phase == 0) begin
            if (req0_valid || req1_valid) begin
                m_owner <= pick_port(req0_valid, req1_valid, m_ptr);
                m_a     <= pick_port(req0_valid, req1_valid, m_ptr) ? req1_a : req0_a;
                m_b     <= pick_port(req0_valid, req1_valid, m_ptr) ? req1_b : req0_b;
                m_op    <= pick_port(req0_valid, req1_valid, m_ptr) ? req1_aluc : req0_aluc;
                order_q.push_back(int'(pick_port(req0_valid, req1_valid, m_ptr)));
                m_phase <= 1;
            end
        end else if (m_phase == 1) begin
            m_rsp   <= expect_rsp(m_a, m_b, m_op);
            m_phase <= 2;
        end else begin
            if (m_owner ? rsp1_ready : rsp0_ready) begin
                m_ptr   <= !m_owner;
                m_phase <= 0;
            end
        end
    end

    // Per-cycle comparison of every DUT output against the reference.
    always @(negedge clk) begin
        chk1("req0_ready", req0_ready, rst_n && m_phase == 0 && req0_valid && !(req1_valid && m_ptr));
        chk1("req1_ready", req1_ready, rst_n && m_phase == 0 && req1_valid && !(req0_valid && !m_ptr));
        chk1("rsp0_valid", rsp0_valid, m_phase == 2 && !m_owner);
        chk1("rsp1_valid", rsp1_valid, m_phase == 2 && m_owner);
        chk32("alu_a", alu_a, (m_phase == 1 && is_legal(m_op)) ? m_a : 32'd0);
        chk32("alu_b", alu_b, (m_phase == 1 && is_legal(m_op)) ? m_b : 32'd0);
        chk32("alu_aluc", 32'(alu_aluc), (m_phase == 1 && is_legal(m_op)) ? 32'(m_op) : 32'd0);
        chk32("rsp_r", rsp_r, m_rsp.r);
        chk1("rsp_zero", rsp_zero, m_rsp.z);
        chk1("rsp_carry", rsp_carry, m_rsp.c);
        chk1("rsp_negative", rsp_negative, m_rsp.n);
        chk1("rsp_overflow", rsp_overflow, m_rsp.v);
        chk1("rsp_flag", rsp_flag, m_rsp.f);
        chk1("rsp_err", rsp_err, m_rsp.e);
    end

    // Requester feeders: per-port op queues presented with valid/ready.
    op_t  q0[$], q1[$];
    logic seen0 = 1'b0, seen1 = 1'b0;
    int   rr_mode = 0;
    logic rand_valid = 1'b0;

    always @(negedge clk) begin
        seen0 <= req0_ready;
        seen1 <= req1_ready;
    end

    always begin
        @(posedge clk);
        #1;
        if (seen0 && q0.size() > 0) void'(q0.pop_front());
        if (seen1 && q1.size() > 0) void'(q1.pop_front());
        if (q0.size() > 0) begin
            req0_a = q0[0].a; req0_b = q0[0].b; req0_aluc = q0[0].op;
            req0_valid = !rand_valid || ($urandom_range(0, 3) != 0);
        end else begin
            req0_a = $urandom; req0_b = $urandom; req0_aluc = 6'($urandom); req0_valid = 1'b0;
        end
        if (q1.size() > 0) begin
            req1_a = q1[0].a; req1_b = q1[0].b; req1_aluc = q1[0].op;
            req1_valid = !rand_valid || ($urandom_range(0, 3) != 0);
        end else begin
            req1_a = $urandom; req1_b = $urandom; req1_aluc = 6'($urandom); req1_valid = 1'b0;
        end
        if (rr_mode == 0) begin
            rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        end else if (rr_mode == 1) begin
            rsp0_ready = 1'($urandom_range(0, 1)); rsp1_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic push_op(input int port, input logic [31:0] a, input logic [31:0] b, input logic [5:0] op);
        op_t t;
        t.a = a; t.b = b; t.op = op;
        if (port == 1) q1.push_back(t);
        else q0.push_back(t);
    endtask

    // Follows one operation of a port: grant, EXEC opcode, response two cycles later.
    task automatic wait_rsp(input int port, input logic [5:0] x_aluc, input logic [31:0] x_r,
                            input logic x_z, input logic x_f, input logic x_e);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (n < 60 && !(port == 1 ? req1_ready : req0_ready));
        if (!(port == 1 ? req1_ready : req0_ready)) begin
            n_checks++; n_err++;
            $display("FAIL grant_timeout: port %0d got no ready within 60 cycles, required grant", port);
            return;
        end
        @(negedge clk);
        chk32("exec_aluc", 32'(alu_aluc), 32'(x_aluc));
        @(negedge clk);
        chk1("lat_rsp_valid", port == 1 ? rsp1_valid : rsp0_valid, 1'b1);
        chk1("other_rsp_valid", port == 1 ? rsp0_valid : rsp1_valid, 1'b0);
        chk32("lit_rsp_r", rsp_r, x_r);
        chk1("lit_zero", rsp_zero, x_z);
        chk1("lit_flag", rsp_flag, x_f);
        chk1("lit_err", rsp_err, x_e);
        chk32("lit_cnv", {29'd0, rsp_carry, rsp_negative, rsp_overflow}, 32'd0);
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        while (n < max_cycles && !(q0.size() == 0 && q1.size() == 0 && m_phase == 0)) begin
            @(negedge clk);
            n++;
        end
        if (!(q0.size() == 0 && q1.size() == 0 && m_phase == 0)) begin
            n_checks++; n_err++;
            $display("FAIL idle_timeout: traffic still pending after %0d cycles, required drained", max_cycles);
        end
        @(negedge clk);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk32("reset_rsp_r", rsp_r, 32'd0);
        chk1("reset_rsp0_valid", rsp0_valid, 1'b0);
        #1 rst_n = 1'b1;

        // Single operation on port 0.
        push_op(0, 32'd5, 32'd3, 6'b100000);
        wait_rsp(0, 6'b100000, 32'd8, 1'b0, 1'b0, 1'b0);
        wait_idle(20);

        // Compare flag passes only for set-less-than; both on port 1 leaves pointer at 0.
        push_op(1, 32'hFFFF_FFFF, 32'd1, 6'b101010);
        wait_rsp(1, 6'b101010, 32'd1, 1'b0, 1'b1, 1'b0);
        wait_idle(20);
        push_op(1, 32'hFFFF_FFFF, 32'd1, 6'b100100);
        wait_rsp(1, 6'b100100, 32'd1, 1'b0, 1'b0, 1'b0);
        wait_idle(20);

        // Contention: alternating service starting with port 0.
        order_q.delete();
        push_op(0, 32'd7, 32'd7, 6'b100011);
        push_op(0, 32'd7, 32'd7, 6'b100011);
        push_op(1, 32'h0000_00F0, 32'h0000_000F, 6'b100101);
        push_op(1, 32'h0000_00F0, 32'h0000_000F, 6'b100101);
        wait_rsp(0, 6'b100011, 32'd0, 1'b1, 1'b0, 1'b0);
        wait_rsp(1, 6'b100101, 32'h0000_00FF, 1'b0, 1'b0, 1'b0);
        wait_idle(40);
        chk32("order_size", 32'(order_q.size()), 32'd4);
        if (order_q.size() >= 4) begin
            chk32("order0", 32'(order_q[0]), 32'd0);
            chk32("order1", 32'(order_q[1]), 32'd1);
            chk32("order2", 32'(order_q[2]), 32'd0);
            chk32("order3", 32'(order_q[3]), 32'd1);
        end

        // Illegal opcode is answered with an error and never reaches the ALU.
        push_op(0, 32'd123, 32'd456, 6'b001000);
        wait_rsp(0, 6'b000000, 32'd0, 1'b0, 1'b0, 1'b1);
        wait_idle(20);

        // Backpressure on port 1 while port 0 waits.
        rr_mode = 2;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b0;
        push_op(1, 32'd1, 32'd2, 6'b100000);
        push_op(0, 32'd3, 32'd4, 6'b100110);
        wait_rsp(1, 6'b100000, 32'd3, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk1("bp_rsp1_valid", rsp1_valid, 1'b1);
            chk32("bp_rsp_r", rsp_r, 32'd3);
            chk1("bp_req0_ready", req0_ready, 1'b0);
        end
        @(posedge clk);
        #1 rsp1_ready = 1'b1;
        @(negedge clk);
        chk1("bp_still_valid", rsp1_valid, 1'b1);
        @(negedge clk);
        chk1("bp_done_valid", rsp1_valid, 1'b0);
        chk1("bp_req0_granted", req0_ready, 1'b1);
        rr_mode = 0;
        wait_idle(20);

        // Reset during EXEC discards the op and returns the pointer to port 0.
        push_op(0, 32'd9, 32'd9, 6'b100000);
        n = 0;
        while (n < 50 && m_phase != 1) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk32("mid_reset_reached_exec", 32'(m_phase), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk1("mid_reset_rsp0_valid", rsp0_valid, 1'b0);
        chk32("mid_reset_rsp_r", rsp_r, 32'd0);
        order_q.delete();
        push_op(0, 32'd1, 32'd1, 6'b100100);
        push_op(1, 32'h0000_0010, 32'h0000_0020, 6'b100001);
        wait_rsp(0, 6'b100100, 32'd1, 1'b0, 1'b0, 1'b0);
        wait_rsp(1, 6'b100001, 32'h0000_0030, 1'b0, 1'b0, 1'b0);
        wait_idle(20);
        if (order_q.size() > 0) chk32("post_reset_first", 32'(order_q[0]), 32'd0);
        else chk32("post_reset_first_size", 32'(order_q.size()), 32'd2);

        // Randomized traffic with random valid gaps and response backpressure.
        rand_valid = 1'b1;
        rr_mode = 1;
        for (int i = 0; i < 120; i++) begin
            push_op(0, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom, $urandom,
                    ($urandom_range(0, 4) == 0) ? 6'($urandom) : LEGAL_OPS[$urandom_range(0, 16)]);
            push_op(1, $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
                    ($urandom_range(0, 4) == 0) ? 6'($urandom) : LEGAL_OPS[$urandom_range(0, 16)]);
        end
        wait_idle(6000);
        rand_valid = 1'b0;
        rr_mode = 0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares the single 32-bit combinational ALU between two requesters: port 0 is the core execute stage, port 1 is the multi-cycle helper unit. It uses round-robin arbitration and registers the operands into the ALU. It captures the result and status flags one cycle later and returns them on a per-requester response handshake. Illegal aluc codes are rejected without launching the ALU.

Parameters:
DATA_W, 32, operand/result width; fixed at 32 to match the ALU.
OP_W, 6, aluc width.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  synchronous active-low reset.
req0_valid  input  1  requester 0 has an operation.
req0_ready  output  1  requester 0 operation accepted this cycle.
req0_a  input  32  operand a.
req0_b  input  32  operand b.
req0_aluc  input  6  ALU opcode.
req1_valid / req1_ready / req1_a / req1_b / req1_aluc  same as port 0, for requester 1.
rsp0_valid  output  1  response for requester 0 is available.
rsp0_ready  input  1  requester 0 takes the response.
rsp1_valid  output  1  response for requester 1 is available.
rsp1_ready  input  1  requester 1 takes the response.
rsp_r  output  32  captured result.
rsp_zero / rsp_carry / rsp_negative / rsp_overflow / rsp_flag  output  1 each  captured ALU status.
rsp_err  output  1  opcode was illegal; result forced to 0.
alu_a  output  32  to ALU a.
alu_b  output  32  to ALU b.
alu_aluc  output  6  to ALU aluc.
alu_r  input  32  from ALU.
alu_zero / alu_carry / alu_negative / alu_overflow / alu_flag  input  1 each  from ALU.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE; priority pointer=0.
  - All req*_ready, rsp*_valid, rsp_* and alu_* outputs are 0.
  - An in-flight operation or a pending response is discarded, not delivered.
- States: IDLE, EXEC, RESP.
- IDLE:
  - Grant goes to the single valid requester. If both are valid, grant goes to the pointer's requester.
  - reqN_ready is combinational, high only in IDLE for the granted N.
  - On the accept edge:
    - latch a, b, aluc and owner;
    - set err_q = aluc not in the legal set;
    - go to EXEC.
  - No valid requester: stay in IDLE.
- Legal aluc set: 100000, 100001, 100010, 100011, 100100, 100101, 100110, 100111, 101010, 101011, 000000, 000010, 000011, 000100, 000110, 000111, 001111. All others are illegal, including 001000.
- EXEC (exactly 1 cycle):
  - alu_a/alu_b/alu_aluc are driven from the latched registers; they are held at 0 in IDLE and when err_q=1.
  - On the edge, capture rsp_r and the flags from the ALU, then go to RESP.
  - If err_q=1: rsp_r=0, all flags 0, rsp_err=1.
  - rsp_flag is captured as alu_flag only for aluc 101010/101011, otherwise 0. A high-Z flag from the ALU must never reach rsp_flag.
  - rsp_carry, rsp_negative and rsp_overflow pass through as delivered by the ALU. Unknown or high-Z values are captured as 0.
- RESP:
  - rsp<owner>_valid=1; the other rsp valid stays 0.
  - rsp_* stay stable while waiting.
  - When rsp<owner>_ready=1 at an edge:
    - pointer becomes the other requester;
    - go to IDLE.
- Latency and throughput:
  - Accept edge T; rsp valid visible after edge T+2 (T+1 is the EXEC capture).
  - Minimum 3 cycles per operation.
  - No new accept while in EXEC or RESP; both req*_ready are 0 there.
- Requesters must hold valid and operands until ready. Dropping valid before ready is legal; nothing is latched.
- The pointer updates only on response completion, not on grant.
- Simultaneous events:
  - A requester may assert valid in the same cycle its response completes; it is considered in the next IDLE cycle.
  - Both valid with pointer=0 → port 0 wins; next contention → port 1 wins.

Test Plan:
- Reset then single op: req0 a=5, b=3, aluc=100000 → req0_ready high one cycle; rsp0_valid 2 cycles later; rsp_r=8, zero=0, rsp_err=0; rsp1_valid stays 0.
- Contention: both valid every cycle, req0 SUBU 7-7, req1 OR 0xF0|0x0F → serviced 0,1,0,1; rsp_r=0 with zero=1 for port 0; rsp_r=0xFF for port 1.
- SLT flag gating: a=0xFFFFFFFF, b=1, aluc=101010 → rsp_r=1, rsp_flag=1; then aluc=100100 → rsp_flag=0 (never X/Z).
- Illegal op: aluc=001000 → alu_aluc stays 0, rsp_err=1, rsp_r=0, all flags 0, response delivered normally.
- Backpressure: rsp1_ready held low 5 cycles → rsp1_valid and rsp_r stable, req0_ready=0 throughout; completes one cycle after rsp1_ready=1.
- Reset mid-operation: rst_n low during EXEC → next cycle IDLE, no rsp_valid; pointer=0; the following op from req1 completes correctly.
